instr_fetch_sequencer: RTL and testbench

//  Fetch-side counterpart of the control unit: walks a PC, reads words from instruction memory (req/ack),

---
 rtl/instr_fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// Fetch sequencer: walks a PC, reads instruction words over req/ack and presents each
// word to the control unit for HOLD_CYCLES clocks, with stall, end-of-window branch and halt.
module instr_fetch_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int INSTR_W     = 32,
    parameter int HOLD_CYCLES = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               imem_ack,
    output logic [INSTR_W-1:0] instruction_memory,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halt
);

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, HALTED} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
    localparam logic [5:0] OP_HALT   = 6'b111111;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               req_q, req_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic               valid_q, valid_d;
    logic               halt_q, halt_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [ADDR_W-1:0]  next_pc;

    assign next_pc = branch_en ? branch_target : pc_q + ADDR_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        req_d   = req_q;
        instr_d = instr_q;
        valid_d = valid_q;
        halt_d  = halt_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
            end
            FETCH: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    instr_d = imem_rdata;
                    if (imem_rdata[INSTR_W-1 -: 6] == OP_HALT) begin
                        state_d = HALTED;
                        halt_d  = 1'b1;
                    end else begin
                        state_d = HOLD;
                        valid_d = 1'b1;
                        cnt_d   = HOLD_LAST;
                    end
                end
            end
            HOLD: begin
                // countdown freezes entirely while stalled; branch only matters on the final edge
                if (!stall) begin
                    if (cnt_q != 8'd0) begin
                        cnt_d = cnt_q - 8'd1;
                    end else begin
                        valid_d = 1'b0;
                        pc_d    = next_pc;
                        addr_d  = next_pc;
                        req_d   = 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            HALTED: ;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            req_q   <= 1'b0;
            instr_q <= '0;
            valid_q <= 1'b0;
            halt_q  <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            halt_q  <= halt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign imem_req           = req_q;
    assign imem_addr          = addr_q;
    assign instruction_memory = instr_q;
    assign instr_valid        = valid_q;
    assign pc                 = pc_q;
    assign halt               = halt_q;

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// Bench for instr_fetch_sequencer: directed scenarios plus randomized traffic, checked each
// cycle against a transaction-level model and against known per-scenario results.
module tb_instr_fetch_sequencer;
    localparam int HC = 10;
    localparam logic [31:0] I_MUL = 32'h0422_4032, I_ADD = 32'h0464_4820;
    localparam logic [31:0] I_SUB = 32'h0509_5022, I_SW  = 32'h0CCA_0000;
    localparam logic [31:0] I_HLT = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0, start = 1'b0, stall = 1'b0, branch_en = 1'b0;
    logic [7:0]  branch_target = 8'd0;
    logic        imem_req, imem_ack = 1'b0;
    logic [7:0]  imem_addr, pc;
    logic [31:0] imem_rdata = 32'd0, instruction_memory;
    logic        instr_valid, halt;

    instr_fetch_sequencer #(.ADDR_W(8), .INSTR_W(32), .HOLD_CYCLES(HC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .branch_en(branch_en),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ack(imem_ack), .instruction_memory(instruction_memory),
        .instr_valid(instr_valid), .pc(pc), .halt(halt)
    );

    always #25 clk = ~clk;

    logic [31:0] mem [256];
    int checks = 0, errors = 0;

    // model: mode 0 idle, 1 waiting on memory, 2 presenting, 3 halted
    int          m_mode = 0, m_used = 0;
    logic [7:0]  m_pc = 0, m_addr = 0;
    logic        m_req = 0, m_valid = 0, m_halt = 0;
    logic [31:0] m_instr = 0;

    int   ack_dly = 1, wait_cnt = 0;
    logic stray_ack = 1'b0;
    logic prev_valid = 1'b0, prev_req = 1'b0;
    int   ff_cycles = 0;
    int          vlen[$];
    logic [31:0] vins[$];
    logic [7:0]  addrs[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic        ack, was_req;
        logic [31:0] rd;
        ack = m_req && (wait_cnt >= ack_dly - 1);
        if (!m_req && stray_ack) ack = 1'b1;
        rd = (ack && m_req) ? mem[m_addr] : $urandom;
        imem_ack   = ack;
        imem_rdata = rd;
        was_req    = m_req;
        if (!rst_n) begin
            m_mode = 0; m_pc = 0; m_addr = 0; m_req = 0; m_valid = 0;
            m_halt = 0; m_instr = 0; m_used = 0;
        end else begin
            case (m_mode)
                0: if (start) begin m_mode = 1; m_req = 1; m_addr = m_pc; end
                1: if (ack) begin
                    m_req = 0; m_instr = rd;
                    if (rd[31:26] == 6'h3f) begin m_mode = 3; m_halt = 1; end
                    else begin m_mode = 2; m_valid = 1; m_used = 0; end
                end
                2: if (!stall) begin
                    m_used++;
                    if (m_used == HC) begin
                        m_valid = 0;
                        m_pc    = branch_en ? branch_target : m_pc + 8'd1;
                        m_req   = 1; m_addr = m_pc; m_mode = 1;
                    end
                end
                default: ;
            endcase
        end
        wait_cnt = (was_req && m_req) ? wait_cnt + 1 : 0;
        @(posedge clk); #1;
        chk("req",   32'(imem_req),    32'(m_req));
        chk("addr",  32'(imem_addr),   32'(m_addr));
        chk("instr", instruction_memory, m_instr);
        chk("valid", 32'(instr_valid), 32'(m_valid));
        chk("pc",    32'(pc),          32'(m_pc));
        chk("halt",  32'(halt),        32'(m_halt));
        if (instr_valid && !prev_valid) begin vins.push_back(instruction_memory); vlen.push_back(0); end
        if (instr_valid) vlen[vlen.size()-1] = vlen[vlen.size()-1] + 1;
        if (imem_req && !prev_req) addrs.push_back(imem_addr);
        if (imem_req && imem_addr == 8'hFF) ff_cycles++;
        prev_valid = instr_valid;
        prev_req   = imem_req;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        for (int i = 0; i < n; i++) step();
        rst_n = 1'b1;
        vlen.delete(); vins.delete(); addrs.delete(); ff_cycles = 0;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        int add_st;
        for (int i = 0; i < 256; i++) mem[i] = $urandom & 32'hFBFF_FFFF;
        mem[0] = I_MUL; mem[1] = I_ADD; mem[2] = I_SUB; mem[3] = I_SW;

        // sequential program with a 5-cycle stall during the add
        do_reset(2);
        step();
        chk("idle_no_req", 32'(imem_req), 32'd0);
        pulse_start();
        add_st = 0;
        for (int i = 0; i < 62; i++) begin
            stall = m_valid && m_instr == I_ADD && add_st < 5 && m_used >= 3;
            if (stall) add_st++;
            step();
        end
        stall = 1'b0;
        chk("seq_count", 32'(vins.size() >= 4), 32'd1);
        if (vins.size() >= 4) begin
            chk("seq_i0", vins[0], I_MUL); chk("seq_i1", vins[1], I_ADD);
            chk("seq_i2", vins[2], I_SUB); chk("seq_i3", vins[3], I_SW);
            chk("len_i0", 32'(vlen[0]), 32'd10); chk("len_add_stalled", 32'(vlen[1]), 32'd15);
            chk("len_i2", 32'(vlen[2]), 32'd10); chk("len_i3", 32'(vlen[3]), 32'd10);
        end
        if (addrs.size() >= 4)
            for (int i = 0; i < 4; i++) chk("seq_addr", 32'(addrs[i]), 32'(i));
        else chk("seq_addr_count", 32'(addrs.size()), 32'd4);

        // reset asserted mid-hold
        for (int i = 0; i < 30 && !m_valid; i++) step();
        chk("mid_hold_reached", 32'(instr_valid), 32'd1);
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instruction_memory, 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        for (int i = 0; i < 5; i++) begin step(); chk("rst_no_req", 32'(imem_req), 32'd0); end

        // branch on the last hold cycle only; an earlier branch_en is ignored
        do_reset(1);
        mem[8'h40] = 32'h1234_5678;
        pulse_start();
        for (int i = 0; i < 40 && addrs.size() < 2; i++) begin
            branch_en     = m_valid && (m_used == 5 || m_used == HC - 1);
            branch_target = (m_used == 5) ? 8'h20 : 8'h40;
            step();
        end
        branch_en = 1'b0;
        chk("br_count", 32'(addrs.size()), 32'd2);
        if (addrs.size() >= 2) chk("br_addr", 32'(addrs[1]), 32'h40);
        for (int i = 0; i < 3; i++) step();
        chk("br_instr", instruction_memory, 32'h1234_5678);

        // halt opcode at address 2
        do_reset(1);
        mem[2] = I_HLT;
        pulse_start();
        for (int i = 0; i < 40; i++) step();
        for (int i = 0; i < 3; i++) begin pulse_start(); step(); end
        chk("halt_flag", 32'(halt), 32'd1);
        chk("halt_valid", 32'(instr_valid), 32'd0);
        chk("halt_req", 32'(imem_req), 32'd0);
        chk("halt_word", instruction_memory, I_HLT);
        chk("halt_pc", 32'(pc), 32'd2);
        chk("halt_fetches", 32'(addrs.size()), 32'd3);
        mem[2] = I_SUB;

        // wrap from 0xFF with a 7-cycle ack latency
        do_reset(1);
        pulse_start();
        for (int i = 0; i < 60 && addrs.size() < 3; i++) begin
            branch_en     = m_valid && m_used == HC - 1 && m_pc == 8'h00;
            branch_target = 8'hFF;
            if (branch_en) ack_dly = 7;
            if (m_valid && m_pc == 8'hFF) ack_dly = 1;
            step();
        end
        branch_en = 1'b0; ack_dly = 1;
        chk("wrap_ff_req_cycles", 32'(ff_cycles), 32'd7);
        chk("wrap_count", 32'(addrs.size()), 32'd3);
        if (addrs.size() >= 3) begin
            chk("wrap_addr_ff", 32'(addrs[1]), 32'hFF);
            chk("wrap_addr_00", 32'(addrs[2]), 32'h00);
        end

        // randomized traffic
        for (int i = 0; i < 4; i++) mem[$urandom_range(5, 255)] = I_HLT | ($urandom & 32'h03FF_FFFF);
        do_reset(1);
        for (int i = 0; i < 2000; i++) begin
            rst_n         = ($urandom_range(0, 249) != 0);
            start         = ($urandom_range(0, 7) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_en     = ($urandom_range(0, 3) == 0);
            branch_target = 8'($urandom);
            stray_ack     = ($urandom_range(0, 5) == 0);
            if (i % 20 == 0) ack_dly = $urandom_range(1, 4);
            step();
        end
        rst_n = 1'b1; start = 1'b0; stall = 1'b0; branch_en = 1'b0; stray_ack = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
